// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-lock filtered PHY reset pulse followed by staged domain reset release
module reset_sequencer #(
  parameter int N_DOMAINS       = 3,
  parameter int LOCK_FILTER     = 1024,
  parameter int PHY_RST_CYCLES  = 250000,
  parameter int PHY_WAIT_CYCLES = 2500000,
  parameter int STAGE_GAP       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pll_lock_i,
  input  logic                 soft_rst_i,
  output logic                 phy_rst_no,
  output logic [N_DOMAINS-1:0] dom_rst_o,
  output logic                 ready_o,
  output logic [7:0]           lock_loss_cnt_o
);

  localparam int REL_CYCLES = (N_DOMAINS - 1) * STAGE_GAP + 1;
  localparam int PHY_MAX    = (PHY_RST_CYCLES > PHY_WAIT_CYCLES) ? PHY_RST_CYCLES : PHY_WAIT_CYCLES;
  localparam int CNT_MAX    = (PHY_MAX > REL_CYCLES) ? PHY_MAX : REL_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int FILT_W     = $clog2(LOCK_FILTER + 1);

  localparam logic [CNT_W-1:0]  PHY_RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PHY_WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REL_LAST      = CNT_W'(REL_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST     = FILT_W'(LOCK_FILTER - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    PHY_RST,
    PHY_WAIT,
    RELEASE,
    RUN
  } state_t;

  state_t                state_q, state_d;
  logic                  lock_meta, lock_s;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FILT_W-1:0]     filt_q, filt_d;
  logic                  lock_lost;
  logic                  phy_rst_n_d;
  logic [N_DOMAINS-1:0]  dom_rst_d;
  logic                  ready_d;
  logic [7:0]            lock_loss_cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock_i;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      filt_q          <= '0;
      phy_rst_no      <= 1'b0;
      dom_rst_o       <= '1;
      ready_o         <= 1'b0;
      lock_loss_cnt_o <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      filt_q          <= filt_d;
      phy_rst_no      <= phy_rst_n_d;
      dom_rst_o       <= dom_rst_d;
      ready_o         <= ready_d;
      lock_loss_cnt_o <= lock_loss_cnt_d;
    end
  end

  // Lock loss is checked ahead of soft reset and phase completion so it always wins.
  always_comb begin
    state_d   = state_q;
    lock_lost = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s && (filt_q == FILT_LAST)) state_d = PHY_RST;
      end
      PHY_RST: begin
        if (!lock_s)                    lock_lost = 1'b1;
        else if (cnt_q == PHY_RST_LAST) state_d   = PHY_WAIT;
      end
      PHY_WAIT: begin
        if (!lock_s)                     lock_lost = 1'b1;
        else if (soft_rst_i)             state_d   = PHY_RST;
        else if (cnt_q == PHY_WAIT_LAST) state_d   = RELEASE;
      end
      RELEASE: begin
        if (!lock_s)                lock_lost = 1'b1;
        else if (soft_rst_i)        state_d   = PHY_RST;
        else if (cnt_q == REL_LAST) state_d   = RUN;
      end
      RUN: begin
        if (!lock_s)         lock_lost = 1'b1;
        else if (soft_rst_i) state_d   = PHY_RST;
      end
      default: state_d = WAIT_LOCK;
    endcase
    if (lock_lost) state_d = WAIT_LOCK;
  end

  always_comb begin
    cnt_d  = '0;
    filt_d = '0;
    if ((state_d == state_q) && (state_q inside {PHY_RST, PHY_WAIT, RELEASE}))
      cnt_d = cnt_q + CNT_W'(1);
    if ((state_d == WAIT_LOCK) && (state_q == WAIT_LOCK) && lock_s)
      filt_d = filt_q + FILT_W'(1);
  end

  // Outputs are decoded from the next state so each register matches the state it enters with.
  always_comb begin
    phy_rst_n_d     = !(state_d inside {WAIT_LOCK, PHY_RST});
    ready_d         = (state_d == RUN);
    lock_loss_cnt_d = lock_loss_cnt_o;
    if (lock_lost && (lock_loss_cnt_o != 8'hFF))
      lock_loss_cnt_d = lock_loss_cnt_o + 8'd1;
    for (int k = 0; k < N_DOMAINS; k++) begin
      dom_rst_d[k] = !((state_d == RUN) ||
                       ((state_d == RELEASE) && (int'(cnt_d) >= k * STAGE_GAP)));
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized self-checking bench for reset_sequencer against a timeline model
module tb_reset_sequencer;

  localparam int ND     = 3;
  localparam int LF     = 4;
  localparam int PR     = 10;
  localparam int PW     = 5;
  localparam int SG     = 3;
  localparam int RUN_AT = PR + PW + (ND - 1) * SG + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pll_lock;
  logic          soft_rst;
  logic          phy_rst_n;
  logic [ND-1:0] dom_rst;
  logic          ready;
  logic [7:0]    loss_cnt;
  logic [12:0]   dut_vec;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_DOMAINS      (ND),
    .LOCK_FILTER    (LF),
    .PHY_RST_CYCLES (PR),
    .PHY_WAIT_CYCLES(PW),
    .STAGE_GAP      (SG)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pll_lock_i     (pll_lock),
    .soft_rst_i     (soft_rst),
    .phy_rst_no     (phy_rst_n),
    .dom_rst_o      (dom_rst),
    .ready_o        (ready),
    .lock_loss_cnt_o(loss_cnt)
  );

  assign dut_vec = {phy_rst_n, dom_rst, ready, loss_cnt};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: lock delay line, whether a sequence is in progress, and cycles elapsed since PHY_RST entry.
  logic [1:0] m_dl;
  bit         m_seq;
  int         m_el;
  int         m_hi;
  int         m_loss;

  task automatic model_reset();
    m_dl   = 2'b00;
    m_seq  = 1'b0;
    m_el   = 0;
    m_hi   = 0;
    m_loss = 0;
  endtask

  task automatic model_edge();
    logic seen;
    seen = m_dl[1];
    m_dl = {m_dl[0], pll_lock};
    if (!m_seq) begin
      if (seen) begin
        m_hi++;
        if (m_hi == LF) begin
          m_seq = 1'b1;
          m_el  = 0;
          m_hi  = 0;
        end
      end else begin
        m_hi = 0;
      end
    end else if (!seen) begin
      m_seq = 1'b0;
      m_hi  = 0;
      if (m_loss < 255) m_loss++;
    end else if (soft_rst && m_el >= PR) begin
      m_el = 0;
    end else if (m_el < RUN_AT) begin
      m_el++;
    end
  endtask

  function automatic logic [12:0] model_vec();
    logic          phy;
    logic [ND-1:0] dom;
    logic          rdy;
    phy = 1'b0;
    dom = '1;
    rdy = 1'b0;
    if (m_seq) begin
      if (m_el >= PR) phy = 1'b1;
      if (m_el >= RUN_AT) begin
        dom = '0;
        rdy = 1'b1;
      end else if (m_el >= PR + PW) begin
        for (int k = 0; k < ND; k++) dom[k] = ((m_el - PR - PW) < k * SG);
      end
    end
    return {phy, dom, rdy, 8'(m_loss)};
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    soft_rst = 1'b0;
    model_reset();
    #12;
    tests++;
    if (dut_vec !== 13'h0E00) begin
      fails++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, 13'h0E00);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_clean_boot();
    int first_phy;
    int first_rdy;
    first_phy = -1;
    first_rdy = -1;
    pll_lock  = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL boot cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
      if (phy_rst_n === 1'b1 && first_phy < 0) first_phy = i;
      if (ready === 1'b1 && first_rdy < 0) first_rdy = i;
    end
    tests++;
    if (first_phy !== 16) begin
      fails++;
      $display("FAIL boot_phy_release got=%0d exp=%0d", first_phy, 16);
    end
    tests++;
    if (first_rdy !== 28) begin
      fails++;
      $display("FAIL boot_ready got=%0d exp=%0d", first_rdy, 28);
    end
  endtask

  task automatic test_lock_loss_run();
    pll_lock = 1'b0;
    repeat (3) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL loss_run cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
    end
    tests++;
    if ({phy_rst_n, dom_rst, ready, loss_cnt} !== {1'b0, 3'b111, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL loss_run_outputs got=%h exp=%h", dut_vec, {1'b0, 3'b111, 1'b0, 8'd1});
    end
    pll_lock = 1'b1;
    repeat (32) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL loss_relock cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL relock_ready got=%b exp=1", ready);
    end
  endtask

  task automatic test_glitch();
    int pattern[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    int first_phy;
    first_phy = -1;
    pll_lock  = 1'b0;
    repeat (4) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL glitch_drop cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
    end
    for (int i = 1; i <= 24; i++) begin
      pll_lock = (i <= 8) ? pattern[i-1][0] : 1'b1;
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
      if (phy_rst_n === 1'b1 && first_phy < 0) first_phy = i;
    end
    tests++;
    if (first_phy !== 20) begin
      fails++;
      $display("FAIL glitch_filter_restart got=%0d exp=%0d", first_phy, 20);
    end
  endtask

  task automatic test_soft_release();
    int saved_loss;
    int first_phy;
    bit hit;
    hit       = 1'b0;
    first_phy = -1;
    pll_lock  = 1'b1;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL soft_lead cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
      if (m_seq && m_el == PR + PW + 4) hit = 1'b1;
    end
    if (!hit) begin
      pll_lock = 1'b0;
      repeat (3) step();
      pll_lock = 1'b1;
      for (int i = 0; i < 60 && !hit; i++) begin
        step();
        if (m_seq && m_el == PR + PW + 4) hit = 1'b1;
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL soft_reach_release got=0 exp=1");
    end
    saved_loss = m_loss;
    soft_rst   = 1'b1;
    step();
    soft_rst   = 1'b0;
    tests++;
    if ({phy_rst_n, dom_rst, loss_cnt} !== {1'b0, 3'b111, 8'(saved_loss)}) begin
      fails++;
      $display("FAIL soft_release_outputs got=%h exp=%h", {phy_rst_n, dom_rst, loss_cnt},
               {1'b0, 3'b111, 8'(saved_loss)});
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL soft_pulse cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
      if (phy_rst_n === 1'b1 && first_phy < 0) first_phy = i;
    end
    tests++;
    if (first_phy !== PR) begin
      fails++;
      $display("FAIL soft_pulse_len got=%0d exp=%0d", first_phy, PR);
    end
  endtask

  task automatic test_priority();
    int exp_loss;
    pll_lock = 1'b1;
    repeat (34) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL prio_lead cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
    end
    pll_lock = 1'b0;
    step();
    step();
    exp_loss = (m_loss < 255) ? m_loss + 1 : 255;
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    tests++;
    if ({phy_rst_n, dom_rst, ready, loss_cnt} !== {1'b0, 3'b111, 1'b0, 8'(exp_loss)}) begin
      fails++;
      $display("FAIL prio_lock_over_soft got=%h exp=%h", dut_vec, {1'b0, 3'b111, 1'b0, 8'(exp_loss)});
    end
    repeat (4) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL prio_tail cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_random();
    repeat (2000) begin
      pll_lock = ($urandom_range(0, 99) < 97);
      soft_rst = ($urandom_range(0, 99) < 3);
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
    end
    soft_rst = 1'b0;
  endtask

  task automatic test_saturation();
    repeat (300) begin
      for (int i = 0; i < 10; i++) begin
        pll_lock = (i < 7);
        step();
        tests++;
        if (dut_vec !== model_vec()) begin
          fails++;
          $display("FAIL sat_event cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
        end
      end
    end
    tests++;
    if (loss_cnt !== 8'd255) begin
      fails++;
      $display("FAIL sat_count got=%0d exp=255", loss_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit hit;
    hit      = 1'b0;
    pll_lock = 1'b1;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL async_lead cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
      if (m_seq && m_el == PR + 2) hit = 1'b1;
    end
    tests++;
    if (!hit || phy_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL async_reach_phy_wait got=%b exp=1", phy_rst_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (dut_vec !== 13'h0E00) begin
      fails++;
      $display("FAIL async_reset_values got=%h exp=%h", dut_vec, 13'h0E00);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (32) begin
      step();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL async_restart cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL async_restart_ready got=%b exp=1", ready);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_boot();
    test_lock_loss_run();
    test_glitch();
    test_soft_release();
    test_priority();
    test_random();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
